// File: rtl/pixel_run_encoder_if.sv
// ---------------------------------------------------------------------------
// pixel_run_encoder_if
//
// Run-record stream from the encoder to its consumer. The head record is
// shown while o_RUN_VALID is high; a record is taken on a cycle where
// o_RUN_VALID and i_RUN_READY are both high.
//
// Signals
//   o_RUN_VALID  record available (FIFO non-empty)
//   i_RUN_READY  consumer accepts the head record
//   o_RUN_START  first column of the run
//   o_RUN_END    last column of the run
//   o_RUN_LINE   line the run was found on
//
// Modports
//   master  encoder side (drives the record, samples ready)
//   slave   consumer side (samples the record, drives ready)
// ---------------------------------------------------------------------------
interface pixel_run_encoder_if;
    logic        o_RUN_VALID;
    logic        i_RUN_READY;
    logic [15:0] o_RUN_START;
    logic [15:0] o_RUN_END;
    logic [15:0] o_RUN_LINE;

    modport master (
        output o_RUN_VALID,
        output o_RUN_START,
        output o_RUN_END,
        output o_RUN_LINE,
        input  i_RUN_READY
    );

    modport slave (
        input  o_RUN_VALID,
        input  o_RUN_START,
        input  o_RUN_END,
        input  o_RUN_LINE,
        output i_RUN_READY
    );
endinterface

// File: rtl/pixel_run_encoder.sv
// ---------------------------------------------------------------------------
// pixel_run_encoder
//
// Binarizes a VGA-timed grayscale pixel stream against a programmable
// threshold, tracks column/line position, and encodes horizontal runs of
// bright pixels into {start, end, line} records held in a first-word
// fall-through FIFO for a downstream consumer.
//
// Parameters
//   MIN_RUN     shortest run (pixels) that produces a record
//   FIFO_DEPTH  run-record FIFO depth, power of two, 2..64
//
// Ports
//   CLK          sole clock, rising edge
//   RST_N        synchronous active-low reset
//   VGA_HS       horizontal sync, falling edge starts a new line
//   VGA_VS       vertical sync, falling edge starts a new frame
//   VGA_DE       active-pixel enable
//   GRAY         pixel luminance
//   THRESHOLD    binarization level, used every cycle
//   BINARY_FLAG  registered binary pixel
//   H_CNT        column of the pixel on BINARY_FLAG
//   V_CNT        line of the pixel on BINARY_FLAG
//   o_RUN_COUNT  runs stored this frame, saturating at 255
//   o_OVERFLOW   a run was dropped on a full FIFO this frame (sticky)
//   run_if       run-record valid/ready stream (master side)
//
// FSM (runs on the registered BINARY_FLAG stream)
//   state    | meaning
//   IDLE     | no open run, waiting for a flagged pixel
//   IN_RUN   | run open, extending end column while pixels stay flagged
// ---------------------------------------------------------------------------
module pixel_run_encoder #(
    parameter int MIN_RUN    = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_DE,
    input  logic [7:0]  GRAY,
    input  logic [7:0]  THRESHOLD,
    output logic        BINARY_FLAG,
    output logic [15:0] H_CNT,
    output logic [15:0] V_CNT,
    output logic [7:0]  o_RUN_COUNT,
    output logic        o_OVERFLOW,
    pixel_run_encoder_if.master run_if
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [16:0]    MIN_LEN = 17'(MIN_RUN);
    localparam logic [0:0]     S_IDLE   = 1'b0;
    localparam logic [0:0]     S_IN_RUN = 1'b1;

    // -----------------------------------------------------------------------
    // Sync edge detection. Both stages clear in reset, so a falling edge can
    // only be seen once a high level has been sampled after release, i.e.
    // two clocks of RST_N=1 at the earliest.
    // -----------------------------------------------------------------------
    logic r_hs_d1, r_hs_d2;
    logic r_vs_d1, r_vs_d2;
    logic w_hs_fall, w_vs_fall;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_hs_d1 <= 1'b0;
            r_hs_d2 <= 1'b0;
            r_vs_d1 <= 1'b0;
            r_vs_d2 <= 1'b0;
        end else begin
            r_hs_d1 <= VGA_HS;
            r_hs_d2 <= r_hs_d1;
            r_vs_d1 <= VGA_VS;
            r_vs_d2 <= r_vs_d1;
        end
    end

    assign w_hs_fall = r_hs_d2 & ~r_hs_d1;
    assign w_vs_fall = r_vs_d2 & ~r_vs_d1;

    // -----------------------------------------------------------------------
    // Column / line counters
    // -----------------------------------------------------------------------
    logic [15:0] r_col;
    logic [15:0] r_line;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_col  <= 16'd0;
            r_line <= 16'd0;
        end else begin
            if (w_hs_fall)
                r_col <= 16'd0;
            else if (VGA_DE)
                r_col <= r_col + 16'd1;

            // Frame start wins over a coincident line start.
            if (w_vs_fall)
                r_line <= 16'd0;
            else if (w_hs_fall)
                r_line <= r_line + 16'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Binarization stage: flag and its coordinates leave together.
    // -----------------------------------------------------------------------
    logic        r_flag;
    logic [15:0] r_hcnt;
    logic [15:0] r_vcnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_flag <= 1'b0;
            r_hcnt <= 16'd0;
            r_vcnt <= 16'd0;
        end else begin
            r_flag <= VGA_DE && (GRAY >= THRESHOLD);
            r_hcnt <= r_col;
            r_vcnt <= r_line;
        end
    end

    assign BINARY_FLAG = r_flag;
    assign H_CNT       = r_hcnt;
    assign V_CNT       = r_vcnt;

    // -----------------------------------------------------------------------
    // Run FSM
    // -----------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [15:0] r_start;
    logic [15:0] r_end;
    logic [15:0] r_run_line;
    logic        r_push_pend;
    logic [47:0] r_push_rec;
    logic        w_close;
    logic [16:0] w_len;
    logic        w_keep;

    // A sync edge forces the open run closed; the flagged pixel seen on that
    // cycle belongs to the old position and is not appended.
    assign w_close = (r_state == S_IN_RUN) && (!r_flag || w_hs_fall || w_vs_fall);
    assign w_len   = {1'b0, r_end - r_start} + 17'd1;
    assign w_keep  = (w_len >= MIN_LEN);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_start     <= 16'd0;
            r_end       <= 16'd0;
            r_run_line  <= 16'd0;
            r_push_pend <= 1'b0;
            r_push_rec  <= 48'd0;
        end else begin
            r_push_pend <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_flag) begin
                        r_state    <= S_IN_RUN;
                        r_start    <= r_hcnt;
                        r_end      <= r_hcnt;
                        r_run_line <= r_vcnt;
                    end
                end
                S_IN_RUN: begin
                    if (w_close) begin
                        r_state     <= S_IDLE;
                        r_push_pend <= w_keep;
                        r_push_rec  <= {r_start, r_end, r_run_line};
                    end else begin
                        r_end <= r_hcnt;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Run-record FIFO (first-word fall-through). Pointers carry one extra
    // wrap bit so full and empty are distinguishable without a counter.
    // -----------------------------------------------------------------------
    logic [47:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [47:0] w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && run_if.i_RUN_READY;
    // A full FIFO still takes the record when the head leaves on the same cycle.
    assign w_push  = r_push_pend && (!w_full || w_pop);
    assign w_drop  = r_push_pend && w_full && !w_pop;

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= r_push_rec;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is not reset, so the fields are masked while nothing is held.
    assign w_head             = w_empty ? 48'd0 : r_mem[r_rd_ptr[AW-1:0]];
    assign run_if.o_RUN_VALID = !w_empty;
    assign run_if.o_RUN_START = w_head[47:32];
    assign run_if.o_RUN_END   = w_head[31:16];
    assign run_if.o_RUN_LINE  = w_head[15:0];

    // -----------------------------------------------------------------------
    // Per-frame statistics. The FIFO itself survives a frame start so the
    // consumer can keep draining; only the statistics restart. A push on the
    // frame-start cycle belongs to the new frame.
    // -----------------------------------------------------------------------
    logic [7:0] r_run_count;
    logic       r_overflow;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_run_count <= 8'd0;
            r_overflow  <= 1'b0;
        end else if (w_vs_fall) begin
            r_run_count <= w_push ? 8'd1 : 8'd0;
            r_overflow  <= w_drop;
        end else begin
            if (w_push && (r_run_count != 8'hFF))
                r_run_count <= r_run_count + 8'd1;
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    assign o_RUN_COUNT = r_run_count;
    assign o_OVERFLOW  = r_overflow;

endmodule

// File: tb/tb_pixel_run_encoder.sv
// ---------------------------------------------------------------------------
// tb_pixel_run_encoder
//
// Drives VGA-style lines (640 active pixels) into pixel_run_encoder. A
// line-level reference model extracts maximal bright runs from each line's
// pixel/threshold arrays and queues the expected records; a consumer monitor
// compares every record the DUT hands over against that queue.
// ---------------------------------------------------------------------------
module tb_pixel_run_encoder;

    localparam int MIN_RUN = 2;
    localparam int DEPTH   = 16;
    localparam int W       = 640;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        VGA_HS, VGA_VS, VGA_DE;
    logic [7:0]  GRAY, THRESHOLD;
    logic        BINARY_FLAG;
    logic [15:0] H_CNT, V_CNT;
    logic [7:0]  o_RUN_COUNT;
    logic        o_OVERFLOW;

    pixel_run_encoder_if rif ();

    pixel_run_encoder #(.MIN_RUN(MIN_RUN), .FIFO_DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .VGA_DE     (VGA_DE),
        .GRAY       (GRAY),
        .THRESHOLD  (THRESHOLD),
        .BINARY_FLAG(BINARY_FLAG),
        .H_CNT      (H_CNT),
        .V_CNT      (V_CNT),
        .o_RUN_COUNT(o_RUN_COUNT),
        .o_OVERFLOW (o_OVERFLOW),
        .run_if     (rif.master)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] s;
        logic [15:0] e;
        logic [15:0] l;
    } rec_t;

    typedef struct packed {
        logic       de;
        logic [7:0] gray;
        logic [7:0] thr;
        logic       exp_flag;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_line   = 0;
    int   m_col    = 0;
    int   exp_count = 0;
    bit   exp_ovf  = 0;
    bit   stall_mode = 0;
    int   ready_mode = 0;   // 0 high, 1 low, 2 toggle, 3 random
    int   pops     = 0;
    int   flag_hi  = 0;
    bit   valid_seen = 0;
    rec_t last_rec;
    rec_t exp_q[$];

    logic [7:0] line_gray [W];
    logic [7:0] line_thr  [W];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic add_record(input rec_t r);
        if (stall_mode && exp_q.size() >= DEPTH) begin
            exp_ovf = 1'b1;
        end else begin
            exp_q.push_back(r);
            if (exp_count < 255) exp_count++;
        end
    endtask

    task automatic model_line_records();
        int st;
        bit f;
        st = -1;
        for (int c = 0; c <= W; c++) begin
            f = (c < W) && (line_gray[c] >= line_thr[c]);
            if (f && st < 0) begin
                st = c;
            end else if (!f && st >= 0) begin
                if (c - st >= MIN_RUN)
                    add_record(rec_t'{16'(st), 16'(c - 1), 16'(m_line)});
                st = -1;
            end
        end
    endtask

    // ---------------- ready driver ----------------
    initial begin
        rif.i_RUN_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0:       rif.i_RUN_READY = 1'b1;
                1:       rif.i_RUN_READY = 1'b0;
                2:       rif.i_RUN_READY = ~rif.i_RUN_READY;
                default: rif.i_RUN_READY = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- consumer monitor ----------------
    bit          stall_prev = 0;
    logic [47:0] prev_fields;

    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            if (rif.o_RUN_VALID) valid_seen = 1'b1;
            if (stall_prev) begin
                check("stall_valid", 64'(rif.o_RUN_VALID), 64'd1);
                check("stall_fields", 64'({rif.o_RUN_START, rif.o_RUN_END, rif.o_RUN_LINE}),
                      64'(prev_fields));
            end
            if (rif.o_RUN_VALID && rif.i_RUN_READY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_record",
                          64'({rif.o_RUN_START, rif.o_RUN_END, rif.o_RUN_LINE}), 64'd0);
                end else begin
                    check("record", 64'({rif.o_RUN_START, rif.o_RUN_END, rif.o_RUN_LINE}),
                          64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                last_rec = {rif.o_RUN_START, rif.o_RUN_END, rif.o_RUN_LINE};
                pops++;
            end
            stall_prev  = rif.o_RUN_VALID && !rif.i_RUN_READY;
            prev_fields = {rif.o_RUN_START, rif.o_RUN_END, rif.o_RUN_LINE};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_pixel(input logic de, input logic [7:0] g, input logic [7:0] thr,
                               input logic exp_flag);
        VGA_DE    = de;
        GRAY      = g;
        THRESHOLD = thr;
        @(posedge CLK);
        #1;
        check("pixel", 64'({BINARY_FLAG, H_CNT, V_CNT}),
              64'({exp_flag, 16'(m_col), 16'(m_line)}));
        if (BINARY_FLAG) flag_hi++;
        if (de) m_col++;
    endtask

    task automatic sync_pulse(input bit vs);
        VGA_DE = 1'b0;
        VGA_HS = 1'b0;
        if (vs) VGA_VS = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        VGA_HS = 1'b1;
        VGA_VS = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        if (vs) begin
            m_line    = 0;
            exp_count = 0;
            exp_ovf   = 1'b0;
        end else begin
            m_line++;
        end
        m_col = 0;
    endtask

    task automatic clear_line(input logic [7:0] thr);
        for (int c = 0; c < W; c++) begin
            line_gray[c] = 8'd20;
            line_thr[c]  = thr;
        end
    endtask

    task automatic bright(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) line_gray[c] = 8'd200;
    endtask

    task automatic run_line(input bit vs);
        sync_pulse(vs);
        model_line_records();
        flag_hi = 0;
        for (int c = 0; c < W; c++)
            drive_pixel(1'b1, line_gray[c], line_thr[c], line_gray[c] >= line_thr[c]);
        repeat (8) drive_pixel(1'b0, 8'd0, line_thr[W-1], 1'b0);
        check("run_count", 64'(o_RUN_COUNT), 64'(exp_count));
        check("overflow", 64'(o_OVERFLOW), 64'(exp_ovf));
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 8'd128, 8'd128, 1'b1};
        tbl[1] = '{1'b1, 8'd127, 8'd128, 1'b0};
        tbl[2] = '{1'b0, 8'd255, 8'd0,   1'b0};
        tbl[3] = '{1'b1, 8'd0,   8'd0,   1'b1};
        tbl[4] = '{1'b1, 8'd200, 8'd201, 1'b0};
        tbl[5] = '{1'b1, 8'd255, 8'd255, 1'b1};
        tbl[6] = '{1'b0, 8'd200, 8'd100, 1'b0};
        tbl[7] = '{1'b1, 8'd100, 8'd99,  1'b1};
        tbl[8] = '{1'b1, 8'd0,   8'd1,   1'b0};
        tbl[9] = '{1'b1, 8'd255, 8'd0,   1'b1};

        RST_N = 1'b0;
        VGA_HS = 1'b1;
        VGA_VS = 1'b1;
        VGA_DE = 1'b0;
        GRAY = 8'd0;
        THRESHOLD = 8'd128;
        repeat (4) @(posedge CLK);
        #1;
        check("rst_flag",  64'(BINARY_FLAG), 64'd0);
        check("rst_hcnt",  64'(H_CNT), 64'd0);
        check("rst_vcnt",  64'(V_CNT), 64'd0);
        check("rst_valid", 64'(rif.o_RUN_VALID), 64'd0);
        check("rst_fields", 64'({rif.o_RUN_START, rif.o_RUN_END, rif.o_RUN_LINE}), 64'd0);
        check("rst_count", 64'(o_RUN_COUNT), 64'd0);
        check("rst_ovf",   64'(o_OVERFLOW), 64'd0);
        RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        // Frame with a 5-pixel run on line 5 (frame start coincides with HS).
        clear_line(8'd128);
        run_line(1'b1);
        check("frame_line0", 64'(V_CNT), 64'd0);
        for (int i = 1; i <= 4; i++) run_line(1'b0);
        bright(10, 14);
        run_line(1'b0);
        check("l5_flag_cycles", 64'(flag_hi), 64'd5);
        wait_drain(50);
        check("l5_record", 64'(last_rec), 64'({16'd10, 16'd14, 16'd5}));
        check("l5_count", 64'(o_RUN_COUNT), 64'd1);

        // Single bright pixel: too short to record.
        clear_line(8'd128);
        bright(30, 30);
        valid_seen = 1'b0;
        run_line(1'b0);
        check("single_flag_cycles", 64'(flag_hi), 64'd1);
        check("single_no_valid", 64'(valid_seen), 64'd0);

        // Run reaching the last active column.
        clear_line(8'd128);
        bright(600, 639);
        run_line(1'b0);
        wait_drain(50);
        check("edge_record", 64'(last_rec), 64'({16'd600, 16'd639, 16'd7}));

        // Table-driven binarization, isolated flags so no records form.
        sync_pulse(1'b0);
        valid_seen = 1'b0;
        foreach (tbl[i]) drive_pixel(tbl[i].de, tbl[i].gray, tbl[i].thr, tbl[i].exp_flag);
        repeat (6) drive_pixel(1'b0, 8'd0, 8'd128, 1'b0);
        check("tbl_no_valid", 64'(valid_seen), 64'd0);
        check("tbl_count", 64'(o_RUN_COUNT), 64'd2);

        // Back-to-back 2-pixel runs with ready toggling.
        ready_mode = 2;
        clear_line(8'd128);
        for (int k = 0; k < 40; k++) bright(100 + 3 * k, 101 + 3 * k);
        pops = 0;
        run_line(1'b0);
        wait_drain(200);
        check("toggle_pops", 64'(pops), 64'd40);
        ready_mode = 0;

        // Overflow: 17 runs of 3 with ready held low.
        wait_drain(50);
        ready_mode = 1;
        repeat (2) @(posedge CLK);
        #1;
        stall_mode = 1'b1;
        clear_line(8'd128);
        for (int k = 0; k < 17; k++) bright(20 + 8 * k, 22 + 8 * k);
        run_line(1'b1);
        check("ovf_count", 64'(o_RUN_COUNT), 64'd16);
        check("ovf_flag",  64'(o_OVERFLOW), 64'd1);
        sync_pulse(1'b1);
        check("vs_clr_count", 64'(o_RUN_COUNT), 64'd0);
        check("vs_clr_ovf",   64'(o_OVERFLOW), 64'd0);
        check("vs_keep_valid", 64'(rif.o_RUN_VALID), 64'd1);
        stall_mode = 1'b0;
        pops = 0;
        ready_mode = 2;
        wait_drain(100);
        check("ovf_drain_pops", 64'(pops), 64'd16);
        ready_mode = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("ovf_empty", 64'(rif.o_RUN_VALID), 64'd0);

        // Reset in the middle of a run (run starts at column 10).
        sync_pulse(1'b0);
        for (int c = 0; c < 12; c++)
            drive_pixel(1'b1, (c >= 10) ? 8'd200 : 8'd20, 8'd128, c >= 10);
        VGA_DE = 1'b1;
        GRAY = 8'd200;
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        check("mrst_flag",  64'(BINARY_FLAG), 64'd0);
        check("mrst_hcnt",  64'(H_CNT), 64'd0);
        check("mrst_vcnt",  64'(V_CNT), 64'd0);
        check("mrst_valid", 64'(rif.o_RUN_VALID), 64'd0);
        check("mrst_count", 64'(o_RUN_COUNT), 64'd0);
        RST_N = 1'b1;
        m_line = 0;
        m_col = 0;
        exp_count = 0;
        exp_ovf = 1'b0;
        valid_seen = 1'b0;
        repeat (10) drive_pixel(1'b0, 8'd0, 8'd128, 1'b0);
        check("mrst_no_record", 64'(valid_seen), 64'd0);
        clear_line(8'd128);
        run_line(1'b0);

        // Randomized frames, threshold changing mid-line, random ready.
        ready_mode = 3;
        for (int fr = 0; fr < 2; fr++) begin
            for (int ln = 0; ln < 5; ln++) begin
                int thr0, thr1, cut, c, len, t;
                bit b;
                thr0 = $urandom_range(1, 255);
                thr1 = $urandom_range(1, 255);
                cut  = $urandom_range(100, 500);
                b    = $urandom_range(0, 1) != 0;
                c    = 0;
                while (c < W) begin
                    len = $urandom_range(1, 12);
                    for (int k = 0; k < len && c < W; k++) begin
                        t = (c < cut) ? thr0 : thr1;
                        line_thr[c]  = 8'(t);
                        line_gray[c] = b ? 8'($urandom_range(t, 255)) : 8'($urandom_range(0, t - 1));
                        c++;
                    end
                    b = !b;
                end
                run_line(ln == 0);
            end
        end
        wait_drain(500);
        ready_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
